stream_capture_core: RTL and testbench
======================================

STREAM_CAPTURE_CORE -- requirements
Module: stream_capture_core

Interface
REQ-001 The module SHALL have parameter BUF_DEPTH, default 16, the number of capture buffer entries.
REQ-002 The module SHALL have parameter X_MAX, default 639, the last visible pixel column.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 x, y  input  11 each  current pixel coordinates from the frame counter.
REQ-006 cs, write, read  input  1 each  video slot select, write strobe and read strobe.
REQ-007 addr  input  14  slot word address; only addr[4:0] is decoded.
REQ-008 wr_data  input  32  write data; rd_data  output  32  read data.
REQ-009 si_rgb  input  12  upstream pixel; so_rgb  output  12  downstream pixel.

Function
REQ-010 Writes (cs & write) SHALL decode addr[4:0] as follows.
- 0: CTRL; bit0 start pulse, bit1 abort pulse, bit2 marker_en held.
- 1: TARGET; tx = wr_data[10:0], ty = wr_data[26:16].
- 2: LEN; wr_data[4:0], 0 stored as 1, values above BUF_DEPTH stored as BUF_DEPTH.
REQ-011 Reads SHALL return combinationally in the same cycle as the address.
- addr[4]=0: STATUS = {25'b0, cnt[4:0], done, busy}.
- addr[4]=1: {20'b0, buf[addr[3:0]]}.
REQ-012 The state machine SHALL have states IDLE, WAIT_SOF, WAIT_POS, CAPTURE and DONE; busy is 1 in WAIT_SOF, WAIT_POS and CAPTURE.
REQ-013 IDLE or DONE with start SHALL go to WAIT_SOF next cycle, clearing cnt to 0 and done to 0.
REQ-014 WAIT_SOF SHALL go to WAIT_POS on the first cycle with x==0 && y==0.
REQ-015 WAIT_POS with x==tx && y==ty SHALL write si_rgb to buf[0] and set cnt=1.
- It SHALL then go to DONE if len==1, else to CAPTURE.
REQ-016 CAPTURE SHALL sample on each cycle where y==ty && x==tx+cnt.
- Each sample writes si_rgb to buf[cnt] and increments cnt.
- When cnt reaches len, the state SHALL go to DONE.
- Repeated cycles at the same x (pixel-tick pacing) SHALL NOT resample.
REQ-017 CAPTURE with y!=ty (line ended) or tx+cnt > X_MAX SHALL go to DONE with the truncated cnt.
REQ-018 Entering DONE SHALL set done=1; done SHALL hold until the next start or abort.
REQ-019 start SHALL be ignored while busy.
REQ-020 abort SHALL move any state to IDLE next cycle, clear done, and keep cnt and buffer contents.
REQ-021 If start and abort are written in the same word, abort SHALL win.
REQ-022 A TARGET or LEN write while busy SHALL take effect immediately; the bench relies only on writes made in IDLE.
REQ-023 so_rgb SHALL be combinational with zero added latency.
- If marker_en && y==ty && tx <= x <= tx+len-1, so_rgb = ~si_rgb.
- Otherwise so_rgb = si_rgb.

Reset
REQ-024 Reset SHALL set state IDLE, busy 0, done 0, cnt 0, tx 0, ty 0, len BUF_DEPTH and marker_en 0.
REQ-025 so_rgb SHALL equal si_rgb during and after reset.
REQ-026 Buffer contents SHALL NOT be reset.
REQ-027 A reset mid-capture SHALL abandon the capture, with no buffer writes after reset asserts.

Structure
REQ-028 Package stream_capture_pkg SHALL hold the state enum, register offsets (CTRL=0, TARGET=1, LEN=2, BUF_BASE=16) and CTRL bit positions.
REQ-029 Sub-module capture_buffer SHALL be a BUF_DEPTH x 12 register file with one synchronous write port and one asynchronous read port.

Verification
REQ-030 Full capture: TARGET tx=100, ty=50; LEN=4; start; x ramps 0..639 with y=50 and si_rgb=x[11:0].
- Required: buf[0..3] = 100..103; STATUS = cnt 4, done 1, busy 0.
REQ-031 Truncation: tx=637, ty=10, LEN=8.
- Required: DONE with cnt=3 after x=639, buf = 637..639.
REQ-032 Start and abort: start then abort in WAIT_POS, before any sample.
- Required: IDLE next cycle, busy 0, done 0, no buffer write.
- Same word start|abort from IDLE: stays IDLE.
REQ-033 Pixel-tick pacing: each x held 4 cycles, LEN=2, tx=5.
- Required: exactly 2 samples, buf = values at x=5 and x=6, cnt 2.
REQ-034 Marker: marker_en=1, tx=20, ty=3, LEN=3, si_rgb=12'h0F0.
- Required: so_rgb=12'hF0F at (20..22, 3); 12'h0F0 elsewhere.
REQ-035 Reset mid-CAPTURE after 2 samples.
- Required: STATUS reads 0; subsequent pixels write nothing; so_rgb = si_rgb.

Source files
------------

// File: rtl/stream_capture_pkg.sv
// stream_capture_pkg: shared capture FSM states, register offsets and CTRL bit positions.
package stream_capture_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_WAIT_POS,
        ST_CAPTURE,
        ST_DONE
    } state_t;
    localparam logic [4:0] REG_CTRL     = 5'd0;
    localparam logic [4:0] REG_TARGET   = 5'd1;
    localparam logic [4:0] REG_LEN      = 5'd2;
    localparam logic [4:0] REG_BUF_BASE = 5'd16;
    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_MARKER = 2;
endpackage

// File: rtl/capture_buffer.sv
// capture_buffer: register file with one synchronous write port and one asynchronous read port.
module capture_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 12
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/stream_capture_core.sv
// stream_capture_core: captures a run of pixels on one video line into a small buffer,
// with an optional on-screen marker over the captured span.
module stream_capture_core
    import stream_capture_pkg::*;
#(
    parameter int BUF_DEPTH = 16,
    parameter int X_MAX     = 639
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [13:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic [11:0] si_rgb,
    output logic [11:0] so_rgb
);
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d, len_q, len_wr;
    logic [10:0] tx_q, ty_q;
    logic        marker_q;
    logic        wr, ctrl_wr, start, abort, on_row, past_end, hit, busy, buf_we;
    logic [11:0] nxt, mark_end, buf_rdata;
    logic        unused_ok;

    assign wr       = cs && write;
    assign ctrl_wr  = wr && addr[4:0] == REG_CTRL;
    assign abort    = ctrl_wr && wr_data[CTRL_ABORT];
    assign start    = ctrl_wr && wr_data[CTRL_START];
    assign on_row   = y == ty_q;
    // Column of the next pixel to sample; cnt is 0 while waiting for the first one.
    assign nxt      = {1'b0, tx_q} + {7'b0, cnt_q};
    assign past_end = nxt > 12'(X_MAX);
    assign hit      = on_row && {1'b0, x} == nxt && !past_end;
    assign busy     = state_q inside {ST_WAIT_SOF, ST_WAIT_POS, ST_CAPTURE};
    assign len_wr   = wr_data[4:0] == 5'd0 ? 5'd1 :
                      wr_data[4:0] > 5'(BUF_DEPTH) ? 5'(BUF_DEPTH) : wr_data[4:0];
    assign mark_end = {1'b0, tx_q} + {7'b0, len_q} - 12'd1;
    assign so_rgb   = (marker_q && on_row && x >= tx_q && {1'b0, x} <= mark_end) ? ~si_rgb : si_rgb;
    assign rd_data  = !(cs && read) ? 32'd0 :
                      addr[4:0] >= REG_BUF_BASE ? {20'd0, buf_rdata} :
                      {25'd0, cnt_q, state_q == ST_DONE, busy};
    assign unused_ok = ^{addr[13:5], wr_data[31:27], wr_data[15:11]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_we  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) begin
                state_d = ST_WAIT_SOF;
                cnt_d   = '0;
            end
            ST_WAIT_SOF: if (x == '0 && y == '0) state_d = ST_WAIT_POS;
            ST_WAIT_POS, ST_CAPTURE: if (hit) begin
                buf_we  = 1'b1;
                cnt_d   = cnt_q + 5'd1;
                state_d = (cnt_q + 5'd1 == len_q) ? ST_DONE : ST_CAPTURE;
            end else if (state_q == ST_CAPTURE && (!on_row || past_end)) begin
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort beats everything, including a start in the same word, and keeps cnt/buffer.
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = cnt_q;
            buf_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            len_q    <= 5'(BUF_DEPTH);
            marker_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ctrl_wr) marker_q <= wr_data[CTRL_MARKER];
            if (wr && addr[4:0] == REG_TARGET) begin
                tx_q <= wr_data[10:0];
                ty_q <= wr_data[26:16];
            end
            if (wr && addr[4:0] == REG_LEN) len_q <= len_wr;
        end

    capture_buffer #(.DEPTH(BUF_DEPTH), .AW(4), .W(12)) u_buf (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (cnt_q[3:0]),
        .wdata_i (si_rgb),
        .raddr_i (addr[3:0]),
        .rdata_o (buf_rdata)
    );
endmodule

// File: tb/tb_stream_capture_core.sv
// tb_stream_capture_core: randomized and directed stimulus checked every cycle against
// an event-level model of the capture rules, plus literal expectations for key scenarios.
module tb_stream_capture_core;
    logic        clk = 1'b0, reset = 1'b1;
    logic [10:0] x = 11'd1000, y = 11'd1000;
    logic        cs = 1'b1, write = 1'b0, read = 1'b1;
    logic [13:0] addr = '0;
    logic [31:0] wr_data = '0, rd_data, v;
    logic [11:0] si_rgb = '0, so_rgb;
    int          n_cmp = 0, n_fail = 0;
    bit          rnd_addr = 1'b0;

    logic        m_active = 0, m_sof = 0, m_done = 0, m_mark = 0;
    int          m_cnt = 0, m_tx = 0, m_ty = 0, m_len = 16;
    logic [11:0] m_buf [16];
    bit          m_bv [16];

    stream_capture_core #(.BUF_DEPTH(16), .X_MAX(639)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .write(write), .read(read),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    // Advances the model by one clock edge using the inputs about to be sampled.
    task automatic model_step();
        bit wr;
        logic [4:0] a;
        int p;
        wr = cs && write;
        a  = addr[4:0];
        if (wr && a == 0 && wr_data[1]) begin
            m_active = 0; m_sof = 0; m_done = 0;
        end else if (wr && a == 0 && wr_data[0] && !m_active) begin
            m_active = 1; m_sof = 0; m_done = 0; m_cnt = 0;
        end else if (m_active && !m_sof) begin
            m_sof = (x == 0 && y == 0);
        end else if (m_active) begin
            p = m_tx + m_cnt;
            if (y == m_ty && x == p && p <= 639) begin
                m_buf[m_cnt] = si_rgb;
                m_bv[m_cnt]  = 1;
                m_cnt++;
                if (m_cnt == m_len) begin m_active = 0; m_done = 1; end
            end else if (m_cnt > 0 && (y != m_ty || p > 639)) begin
                m_active = 0; m_done = 1;
            end
        end
        if (wr && a == 0) m_mark = wr_data[2];
        if (wr && a == 1) begin m_tx = wr_data[10:0]; m_ty = wr_data[26:16]; end
        if (wr && a == 2) m_len = wr_data[4:0] == 0 ? 1 : wr_data[4:0] > 16 ? 16 : int'(wr_data[4:0]);
    endtask

    initial forever begin
        logic [11:0] exp_so;
        @(negedge clk);
        if (reset) begin
            m_active = 0; m_sof = 0; m_done = 0; m_cnt = 0;
            m_tx = 0; m_ty = 0; m_len = 16; m_mark = 0;
        end
        exp_so = (m_mark && y == m_ty && x >= m_tx && x <= m_tx + m_len - 1) ? ~si_rgb : si_rgb;
        check("so_rgb", {20'd0, so_rgb}, {20'd0, exp_so});
        if (addr[4]) begin
            if (m_bv[addr[3:0]]) check("buf_read", rd_data, {20'd0, m_buf[addr[3:0]]});
        end else begin
            check("status", rd_data, {25'd0, 5'(m_cnt), m_done, m_active});
        end
        if (!reset) model_step();
    end

    task automatic px(input int xx, input int yy, input logic [11:0] c);
        @(posedge clk); #1;
        x = 11'(xx); y = 11'(yy); si_rgb = c;
        if (rnd_addr) addr = 14'($urandom_range(0, 31));
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        write = 1; addr = {9'd0, a}; wr_data = d;
        @(posedge clk); #1;
        write = 0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        addr = {9'd0, a};
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic target(input int tx, input int ty);
        wr(5'd1, {5'd0, 11'(ty), 5'd0, 11'(tx)});
    endtask

    task automatic line(input int yy, input int hold, input int mode);
        for (int xx = 0; xx < 640; xx++)
            repeat (hold) px(xx, yy, mode == 0 ? 12'(xx) : mode == 1 ? 12'(xx + 256) : 12'($urandom));
    endtask

    task automatic park();
        px(1000, 1000, 12'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 0;
        rd(0, v); check("reset_status", v, 0);

        // full capture
        park(); target(100, 50); wr(2, 4); wr(0, 1); px(0, 0, 0); line(50, 1, 0);
        repeat (3) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            rd(5'(16 + i), v); check("full_buf", v, 32'(100 + i));
        end
        rd(0, v); check("full_status", v, 32'h12);

        // truncation at the right edge
        park(); target(637, 10); wr(2, 8); wr(0, 1); px(0, 0, 0); line(10, 1, 0);
        repeat (3) @(posedge clk);
        rd(0, v); check("trunc_status", v, 32'h0E);
        for (int i = 0; i < 3; i++) begin
            rd(5'(16 + i), v); check("trunc_buf", v, 32'(637 + i));
        end
        rd(19, v); check("trunc_buf3_kept", v, 103);

        // start then abort before any sample; start|abort together from idle
        park(); target(100, 50); wr(0, 1); px(0, 0, 0); park();
        rd(0, v); check("wait_pos_busy", v, 1);
        wr(0, 2);
        rd(0, v); check("abort_status", v, 0);
        rd(16, v); check("abort_no_write", v, 637);
        wr(0, 3);
        rd(0, v); check("start_abort_status", v, 0);
        px(0, 0, 0); line(50, 1, 0);
        repeat (2) @(posedge clk);
        rd(0, v); check("start_abort_idle", v, 0);
        rd(16, v); check("start_abort_no_write", v, 637);

        // pixel-tick pacing
        park(); target(5, 7); wr(2, 2); wr(0, 1); px(0, 0, 0); line(7, 4, 1);
        repeat (3) @(posedge clk);
        rd(16, v); check("pace_buf0", v, 32'h105);
        rd(17, v); check("pace_buf1", v, 32'h106);
        rd(18, v); check("pace_buf2_kept", v, 639);
        rd(0, v); check("pace_status", v, 32'h0A);

        // marker overlay
        park(); target(20, 3); wr(2, 3); wr(0, 4);
        for (int yy = 2; yy <= 4; yy++)
            for (int xx = 15; xx <= 25; xx++) begin
                px(xx, yy, 12'h0F0);
                @(negedge clk);
                check("marker_so", {20'd0, so_rgb},
                      (yy == 3 && xx >= 20 && xx <= 22) ? 32'hF0F : 32'h0F0);
            end
        wr(0, 0);

        // reset in the middle of a capture
        park(); target(100, 50); wr(2, 8); wr(0, 1); px(0, 0, 0);
        for (int xx = 0; xx <= 102; xx++) px(xx, 50, 12'(xx));
        reset = 1; si_rgb = 12'hABC;
        @(negedge clk);
        check("reset_so_pass", {20'd0, so_rgb}, 32'hABC);
        rd(0, v); check("reset_mid_status", v, 0);
        @(posedge clk); #1 reset = 0;
        for (int xx = 103; xx <= 200; xx++) px(xx, 50, 12'(xx));
        rd(0, v); check("post_reset_status", v, 0);
        rd(16, v); check("post_reset_buf0", v, 100);
        rd(17, v); check("post_reset_buf1", v, 101);
        rd(18, v); check("post_reset_buf2", v, 639);

        // randomized captures, with reads from random addresses every cycle
        rnd_addr = 1;
        for (int it = 0; it < 8; it++) begin
            int tx, ty, ln, mk;
            tx = it < 3 ? $urandom_range(630, 639) : $urandom_range(0, 639);
            ty = $urandom_range(1, 20);
            ln = $urandom_range(0, 31);
            mk = $urandom_range(0, 1);
            park(); target(tx, ty); wr(2, 32'(ln)); wr(0, {29'd0, 1'(mk), 2'b01});
            px(0, 0, 12'($urandom));
            if (it % 3 == 0) wr(0, {29'd0, 1'(mk), 2'b01});
            line(ty, $urandom_range(1, 2), 2);
            line(ty + 1, 1, 2);
        end
        rnd_addr = 0;
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
